// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_seq execute unit.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_PASSB = 3'b000,
        OP_RSVD  = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_MUL   = 3'b111
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLG_N  = 3;
    localparam int unsigned FLG_Z  = 2;
    localparam int unsigned FLG_V  = 1;
    localparam int unsigned FLG_C  = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Operand and result handshake bundle between the issue stage and alu_seq.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 64
);
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    alu_op_t             op;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    result;
    logic [FLAG_W-1:0]   flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: pass, add/sub, logic ops; reserved and MUL slots yield zero.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned SW = WIDTH + 1;

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [SW-1:0]    sum;

    always_comb begin
        sub      = (op == OP_SUB);
        b_eff    = sub ? ~b : b;
        sum      = SW'(a) + SW'(b_eff) + SW'(sub);
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_PASSB: result = b;
            OP_ADD,
            OP_SUB: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                // signed overflow: like-signed operands produce a differently-signed sum
                overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// ALU execute unit: single-cycle ops via alu_comb, iterative shift-add multiply,
// and a single-entry registered output buffer with valid/ready handshakes.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_seq_if.slave   bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    state_t              state;
    state_t              state_next;
    logic                rst_done;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       mcand;
    logic [PW-1:0]       acc_step;
    logic [WIDTH-1:0]    mplier;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    result_q;
    logic [FLAG_W-1:0]   flags_q;
    logic                out_valid_q;

    logic                in_ready;
    logic                accept;
    logic                drain;
    logic                start_mul;
    logic                mul_done;
    logic                load;
    logic [WIDTH-1:0]    res_d;
    logic [FLAG_W-1:0]   flags_d;
    logic [WIDTH-1:0]    comb_result;
    logic                comb_carry;
    logic                comb_ovf;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a        (bus.a),
        .b        (bus.b),
        .op       (bus.op),
        .result   (comb_result),
        .carry    (comb_carry),
        .overflow (comb_ovf)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake decode, next state, multiplier step and output-buffer load values
    always_comb begin
        state_next = state;
        in_ready   = rst_done && (state == IDLE) && (!out_valid_q || bus.out_ready);
        accept     = in_ready && bus.in_valid;
        drain      = out_valid_q && bus.out_ready;
        start_mul  = accept && MUL_EN && (bus.op == OP_MUL);
        mul_done   = (state == MUL) && (cnt == CW'(WIDTH - 1));
        load       = (accept && !start_mul) || mul_done;
        acc_step   = acc + (mplier[0] ? mcand : '0);

        case (state)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        res_d   = comb_result;
        flags_d = '0;
        if (mul_done) begin
            res_d          = acc_step[WIDTH-1:0];
            flags_d[FLG_C] = |acc_step[PW-1:WIDTH];
        end else begin
            flags_d[FLG_C] = comb_carry;
            flags_d[FLG_V] = comb_ovf;
        end
        flags_d[FLG_N] = res_d[WIDTH-1];
        flags_d[FLG_Z] = (res_d == '0);
    end

    // Multiplier datapath and output buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_done    <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (start_mul) begin
                acc    <= '0;
                mcand  <= PW'(bus.a);
                mplier <= bus.b;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            // a MUL is only accepted into an empty/draining buffer, so mul_done never collides
            if (load) begin
                result_q    <= res_d;
                flags_q     <= flags_d;
                out_valid_q <= 1'b1;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   tests  = 0;
    int   failed = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; caller ensures in_ready is high.
    task automatic issue(input alu_op_t op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] res, input logic [3:0] flg);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
        check({tag, "_result"}, 64'(bus.result), 64'(res));
        check({tag, "_flags"}, 64'(bus.flags), 64'(flg));
    endtask

    initial begin
        logic ever_valid;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = OP_PASSB;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_same", 64'(bus.in_ready), 64'd0);
        tick();
        check("rel_in_ready_next", 64'(bus.in_ready), 64'd1);

        // Single-cycle ops, issued back to back
        issue(OP_ADD, 8'h7F, 8'h01);  expect_out("add_ovf", 8'h80, 4'b1010);
        issue(OP_ADD, 8'hFF, 8'h01);  expect_out("add_cry", 8'h00, 4'b0101);
        issue(OP_SUB, 8'h05, 8'h05);  expect_out("sub_eq",  8'h00, 4'b0101);
        issue(OP_SUB, 8'h00, 8'h01);  expect_out("sub_brw", 8'hFF, 4'b1000);
        issue(OP_AND, 8'hF0, 8'h3C);  expect_out("and",     8'h30, 4'b0000);
        issue(OP_OR,  8'hF0, 8'h3C);  expect_out("or",      8'hFC, 4'b1000);
        issue(OP_XOR, 8'hF0, 8'h3C);  expect_out("xor",     8'hCC, 4'b1000);
        issue(OP_PASSB, 8'hF0, 8'h3C); expect_out("pass",   8'h3C, 4'b0000);
        issue(OP_RSVD, 8'hF0, 8'h3C); expect_out("rsvd",    8'h00, 4'b0100);

        // Multiply 13*11: busy for 8 cycles, result in the 9th
        issue(OP_MUL, 8'd13, 8'd11);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mul1_busy_c%0d", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("mul1_nvld_c%0d", i), 64'(bus.out_valid), 64'd0);
            tick();
        end
        expect_out("mul1", 8'h8F, 4'b1000);
        check("mul1_ready_after", 64'(bus.in_ready), 64'd1);

        // Multiply with a non-zero high half: 0x20*0x10 = 0x0200
        issue(OP_MUL, 8'h20, 8'h10);
        for (int i = 1; i <= 8; i++) tick();
        expect_out("mul2", 8'h00, 4'b0101);

        // Backpressure: result holds, nothing accepted
        issue(OP_ADD, 8'd3, 8'd4);
        bus.out_ready = 1'b0;
        #1;
        expect_out("bp_load", 8'h07, 4'b0000);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 8'd1;
        bus.b        = 8'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
            tick();
            check($sformatf("bp_hold_res_%0d", i), 64'(bus.result), 64'h07);
            check($sformatf("bp_hold_vld_%0d", i), 64'(bus.out_valid), 64'd1);
        end
        // Drain and accept in the same cycle
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        expect_out("bp_same_cycle", 8'h02, 4'b0000);

        // Reset during multiply aborts it
        issue(OP_MUL, 8'd3, 8'd3);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mulrst_valid", 64'(bus.out_valid), 64'd0);
        check("mulrst_result", 64'(bus.result), 64'd0);
        check("mulrst_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        ever_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ever_valid = ever_valid | bus.out_valid;
        end
        check("mulrst_no_valid", 64'(ever_valid), 64'd0);
        check("mulrst_idle_ready", 64'(bus.in_ready), 64'd1);
        issue(OP_ADD, 8'd2, 8'd3);
        expect_out("post_rst_add", 8'h05, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
